// File: rtl/DEBUG_BRIDGE_PKG.sv
// Shared command/reply byte codes and FSM state encoding for the UART debug bridge.
package DEBUG_BRIDGE_PKG;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_PING  = 8'h50;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR2,
    ADDR1,
    ADDR0,
    DATA,
    MEM,
    RESP,
    RESP_WAIT
  } state_e;

endpackage

// File: rtl/debug_bridge_timeout.sv
// Inter-byte gap counter: cleared on each accepted byte, counts while enabled,
// and flags expiry when it reaches TIMEOUT_CYCLES-1.
module debug_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 10_800_000
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic CLR,
  input  logic EN,
  output logic EXPIRED
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturate at LAST so a stalled enable can never wrap back into a live window.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (EN && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign EXPIRED = EN && (cnt_q == LAST);

endmodule

// File: rtl/uart_debug_bridge.sv
// UART command decoder that turns R/W/P byte sequences into single-byte RAM
// accesses and sends one reply byte per command.
module uart_debug_bridge
  import DEBUG_BRIDGE_PKG::*;
#(
  parameter int TIMEOUT_CYCLES = 10_800_000,
  parameter int ADDR_WIDTH     = 24
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic [7:0]            TX_DATA,
  output logic                  TX_STROBE,
  input  logic                  TX_BUSY,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [7:0]            RAM_DIN,
  input  logic [7:0]            RAM_DOUT,
  output logic                  RAM_OE_n,
  output logic                  RAM_WE_n,
  input  logic                  RAM_ACK_n,
  output logic                  OVERRUN
);

  state_e                state_q, state_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            din_q, din_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_strobe_q, tx_strobe_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  overrun_q, overrun_d;
  logic                  counting;
  logic                  expired;
  logic                  rx_accept;

  assign counting = (state_q == ADDR2) || (state_q == ADDR1) ||
                    (state_q == ADDR0) || (state_q == DATA);

  debug_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK    (CLK),
    .RESET_n(RESET_n),
    .CLR    (rx_accept),
    .EN     (counting),
    .EXPIRED(expired)
  );

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    din_d       = din_q;
    tx_data_d   = tx_data_q;
    tx_strobe_d = 1'b0;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    overrun_d   = overrun_q;
    rx_accept   = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_VALID) begin
          rx_accept = 1'b1;
          if ((RX_DATA == CMD_READ) || (RX_DATA == CMD_WRITE)) begin
            is_write_d = (RX_DATA == CMD_WRITE);
            addr_d     = '0;
            state_d    = ADDR2;
          end else begin
            tx_data_d = (RX_DATA == CMD_PING) ? RSP_OK : RSP_ERR;
            state_d   = RESP;
          end
        end
      end
      // Address bytes arrive MSB first; shifting drops any bits above ADDR_WIDTH.
      ADDR2, ADDR1, ADDR0: begin
        if (expired) begin
          state_d = IDLE;
        end else if (RX_VALID) begin
          rx_accept = 1'b1;
          addr_d    = {addr_q[ADDR_WIDTH-9:0], RX_DATA};
          if (state_q == ADDR2) begin
            state_d = ADDR1;
          end else if (state_q == ADDR1) begin
            state_d = ADDR0;
          end else if (is_write_q) begin
            state_d = DATA;
          end else begin
            oe_n_d  = 1'b0;
            state_d = MEM;
          end
        end
      end
      DATA: begin
        if (expired) begin
          state_d = IDLE;
        end else if (RX_VALID) begin
          rx_accept = 1'b1;
          din_d     = RX_DATA;
          we_n_d    = 1'b0;
          state_d   = MEM;
        end
      end
      MEM: begin
        if (!RAM_ACK_n) begin
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          tx_data_d = is_write_q ? RSP_OK : RAM_DOUT;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (!TX_BUSY) begin
          tx_strobe_d = 1'b1;
          state_d     = RESP_WAIT;
        end
      end
      // The strobe cycle is skipped because TX_BUSY only rises one cycle after it.
      RESP_WAIT: begin
        if (!tx_strobe_q && !TX_BUSY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (RX_VALID && ((state_q == MEM) || (state_q == RESP) || (state_q == RESP_WAIT))) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      tx_data_q   <= '0;
      tx_strobe_q <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      tx_data_q   <= tx_data_d;
      tx_strobe_q <= tx_strobe_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      overrun_q   <= overrun_d;
    end
  end

  assign TX_DATA   = tx_data_q;
  assign TX_STROBE = tx_strobe_q;
  assign RAM_ADDR  = addr_q;
  assign RAM_DIN   = din_q;
  assign RAM_OE_n  = oe_n_q;
  assign RAM_WE_n  = we_n_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: doc/uart_debug_bridge.md
UART_DEBUG_BRIDGE -- requirements
Module: uart_debug_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 10_800_000, inter-byte gap (100 ms at 108 MHz) after which a partial command is discarded.
REQ-002 SHALL have parameter ADDR_WIDTH, default 24, RAM byte-address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, ports named CLK and RESET_n.
REQ-004 CLK  input  1  system clock, 108 MHz.
REQ-005 RESET_n  input  1  asynchronous active-low reset.
REQ-006 RX_DATA  input  8  received UART byte, valid only while RX_VALID=1.
REQ-007 RX_VALID  input  1  one-cycle pulse per received byte.
REQ-008 TX_DATA  output  8  byte to transmit.
REQ-009 TX_STROBE  output  1  one-cycle transmit request.
REQ-010 TX_BUSY  input  1  transmitter busy; rises the cycle after TX_STROBE, falls when the byte is sent.
REQ-011 RAM_ADDR  output  ADDR_WIDTH  RAM byte address.
REQ-012 RAM_DIN  output  8  RAM write data.
REQ-013 RAM_DOUT  input  8  RAM read data, valid in the cycle RAM_ACK_n=0.
REQ-014 RAM_OE_n / RAM_WE_n  output  1 each  active-low read / write request.
REQ-015 RAM_ACK_n  input  1  active-low one-cycle completion.
REQ-016 OVERRUN  output  1  sticky flag: a byte was dropped.

Function
REQ-017 Command set: 'R'(0x52) A2 A1 A0 reads one byte; 'W'(0x57) A2 A1 A0 D writes one byte; 'P'(0x50) pings. Address bytes are big-endian; bits above ADDR_WIDTH are ignored.
REQ-018 Replies: R returns the byte read; W and P return 'K'(0x4B); any other first byte returns '?'(0x3F).
REQ-019 FSM states: IDLE, ADDR2, ADDR1, ADDR0, DATA, MEM, RESP, RESP_WAIT.
REQ-020 IDLE: on RX_VALID, R/W go to ADDR2; P and unknown bytes go to RESP with the reply latched.
REQ-021 ADDR2 -> ADDR1 -> ADDR0 each advance on RX_VALID, latching one address byte; after A0, R goes to MEM and W goes to DATA.
REQ-022 DATA: on RX_VALID, latch RAM_DIN and go to MEM.
REQ-023 MEM: assert RAM_OE_n=0 (R) or RAM_WE_n=0 (W) from the first MEM cycle, with RAM_ADDR/RAM_DIN stable, held until RAM_ACK_n=0 is sampled. The request is deasserted the next cycle. On R, RAM_DOUT is captured in the ACK cycle. Then go to RESP.
REQ-024 RESP: TX_STROBE=1 for exactly one cycle, only in a cycle with TX_BUSY=0, then go to RESP_WAIT.
REQ-025 RESP_WAIT: skip one cycle, then return to IDLE when TX_BUSY=0.
REQ-026 Latency: a write request asserts 1 cycle after the RX_VALID of the D byte. A read request asserts 1 cycle after the RX_VALID of A0. TX_STROBE asserts at earliest 1 cycle after RAM_ACK_n=0.
REQ-027 Timeout counter: resets on every accepted byte and counts only in ADDR2/ADDR1/ADDR0/DATA. At TIMEOUT_CYCLES-1 the FSM returns to IDLE with no reply and no RAM access.
REQ-028 RX_VALID in MEM, RESP or RESP_WAIT drops the byte and sets OVERRUN=1. Simultaneous RX_VALID and timeout: the timeout wins and the byte is dropped without setting OVERRUN.
REQ-029 TX_DATA is held stable from TX_STROBE until return to IDLE.

Reset
REQ-030 Reset values: state IDLE, TX_STROBE=0, TX_DATA=0, RAM_OE_n=1, RAM_WE_n=1, RAM_ADDR=0, RAM_DIN=0, OVERRUN=0, timeout counter=0.
REQ-031 Reset asserted mid-operation, including with a RAM request pending, deasserts all requests asynchronously. An ACK arriving after release is ignored in IDLE.

Structure
REQ-032 Command/reply byte constants and the state enum belong in shared package DEBUG_BRIDGE_PKG.
REQ-033 The inter-byte timeout counter is one sub-module, debug_bridge_timeout (inputs CLK, RESET_n, CLR, EN; output EXPIRED; width $clog2(TIMEOUT_CYCLES)).

Verification
REQ-034 Write: bytes 57 01 23 45 A5 -> RAM_WE_n=0 with RAM_ADDR=0x012345 and RAM_DIN=0xA5 until ACK; then one TX_STROBE with TX_DATA=0x4B.
REQ-035 Read: bytes 52 00 00 10, RAM responds RAM_DOUT=0x3C with ACK after 5 cycles -> RAM_OE_n low for 6 cycles; TX_DATA=0x3C strobed once.
REQ-036 Unknown and ping: 0x00 -> reply 0x3F; 0x50 -> reply 0x4B; neither asserts RAM_OE_n or RAM_WE_n.
REQ-037 Timeout (TIMEOUT_CYCLES=100): bytes 57 01, then idle 100 cycles, then 50 -> only reply 0x4B; no RAM write.
REQ-038 Overrun: a byte is sent while MEM waits on ACK -> OVERRUN=1 and stays 1; the command completes normally.
REQ-039 Backpressure/reset: TX_BUSY held 1 in RESP delays TX_STROBE until it falls. Reset pulsed during MEM -> RAM_OE_n=1 immediately, state IDLE, no reply.
